// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared NAND 4:1 MUX. It drives the MUX selects and a
// one-hot grant, and raises out_valid only after the select path has settled.
module mux_rr_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GRANT  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] HOLD_TOP  = 8'(MAX_HOLD - 1);

  // Scan last+1, last+2, last+3, last; the earliest index with a request wins.
  function automatic logic [2:0] f_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    f_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        f_pick = {1'b1, idx};
      end else begin
        f_pick = f_pick;
      end
    end
  endfunction

  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    f_onehot = 4'b0001 << idx;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic       r_out_valid, w_out_valid_nxt;
  logic       r_busy, w_busy_nxt;
  logic [1:0] r_last, w_last_nxt;
  logic [3:0] r_settle_cnt, w_settle_cnt_nxt;
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;

  logic [2:0] w_idle_pick;
  logic [2:0] w_leave_pick;
  logic       w_others;
  logic       w_leave;

  assign w_idle_pick  = f_pick(req, r_last);
  // On leaving, the owner becomes the new "last", so the scan starts from r_sel.
  assign w_leave_pick = f_pick(req, r_sel);
  assign w_others     = |(req & ~r_gnt);
  assign w_leave      = ~req[r_sel] |
                        ((r_state == ST_GRANT) & (r_hold_cnt == HOLD_TOP) & w_others);

  // Next-state and next-output computation.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_gnt_nxt        = r_gnt;
    w_out_valid_nxt  = r_out_valid;
    w_busy_nxt       = r_busy;
    w_last_nxt       = r_last;
    w_settle_cnt_nxt = r_settle_cnt;
    w_hold_cnt_nxt   = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_pick[2]) begin
          w_state_nxt      = ST_SETTLE;
          w_sel_nxt        = w_idle_pick[1:0];
          w_gnt_nxt        = f_onehot(w_idle_pick[1:0]);
          w_busy_nxt       = 1'b1;
          w_settle_cnt_nxt = SETTLE_LD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE, ST_GRANT: begin
        if (w_leave) begin
          w_last_nxt      = r_sel;
          w_out_valid_nxt = 1'b0;
          w_hold_cnt_nxt  = 8'd0;
          if (w_leave_pick[2]) begin
            // Direct handoff: no idle bubble between owners.
            w_state_nxt      = ST_SETTLE;
            w_sel_nxt        = w_leave_pick[1:0];
            w_gnt_nxt        = f_onehot(w_leave_pick[1:0]);
            w_settle_cnt_nxt = SETTLE_LD;
          end else begin
            w_state_nxt      = ST_IDLE;
            w_gnt_nxt        = 4'b0000;
            w_busy_nxt       = 1'b0;
            w_settle_cnt_nxt = 4'd0;
          end
        end else if (r_state == ST_SETTLE) begin
          if (r_settle_cnt == 4'd1) begin
            w_state_nxt     = ST_GRANT;
            w_out_valid_nxt = 1'b1;
            w_hold_cnt_nxt  = 8'd0;
          end else begin
            w_settle_cnt_nxt = r_settle_cnt - 4'd1;
          end
        end else begin
          if (r_hold_cnt != HOLD_TOP) begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt;
          end
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_sel_nxt        = 2'b00;
        w_gnt_nxt        = 4'b0000;
        w_out_valid_nxt  = 1'b0;
        w_busy_nxt       = 1'b0;
        w_last_nxt       = 2'd3;
        w_settle_cnt_nxt = 4'd0;
        w_hold_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State and output registers; last=3 so the first grant after reset goes to req[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= 2'b00;
      r_gnt        <= 4'b0000;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_last       <= 2'd3;
      r_settle_cnt <= 4'd0;
      r_hold_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_gnt        <= w_gnt_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_last       <= w_last_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
    end
  end

  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule
